a3_sigmoid: RTL and testbench
=============================

A3_SIGMOID -- requirements
Module: a3_sigmoid

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the sample counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port z3  input  8  signed Q4.4 pre-activation sum from the output-layer accumulator.
REQ-005 SHALL have port in_valid  input  1  z3 is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts z3 this cycle.
REQ-007 SHALL have port a3  output  16  sigmoid(z3), unsigned value in signed Q6.10, range 0x000..0x400.
REQ-008 SHALL have port out_valid  output  1  a3 (and a3_deriv) are valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the output.
REQ-010 SHALL have port a3_deriv  output  16  a3*(1-a3) in Q6.10; present only with A3_DERIV_EN.
REQ-011 SHALL have port sample_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-012 SHALL accept an input when in_valid && in_ready, and complete an output when out_valid && out_ready.
REQ-013 SHALL use a stall-based pipeline: stall = out_valid && !out_ready; in_ready = !stall; all stages hold while stalled.
REQ-014 SHALL use latency 2 cycles from input acceptance to out_valid without A3_DERIV_EN, and 3 cycles with it.
REQ-015 SHALL sustain 1 sample/cycle when out_ready is held high, with no bubbles inserted.
REQ-016 Stage 1 SHALL register the sign, |z3| (9-bit to hold |-8|) and a segment index (0..3).
REQ-017 SHALL use PLAN segments on |x|: [0,1) y=0.25|x|+0.5; [1,2.375) y=0.125|x|+0.625; [2.375,5) y=0.03125|x|+0.84375; >=5 y=1.0.
REQ-018 Stage 2 SHALL compute y from shifts and adds only, exactly in Q6.10 with no rounding, and output 1.0-y (0x400-y) for negative z3.
REQ-019 SHALL map z3=-8.0 (0x80) to a3=0x000 and z3=7.9375 (0x7F) to a3=0x400.
REQ-020 SHALL increment sample_cnt on each completed output transfer and wrap from all-ones to 0.
REQ-021 SHALL let in-flight samples with a bubble (invalid) ahead advance without a stall; only a valid, unaccepted output blocks.

Reset
REQ-022 SHALL, on reset assertion, immediately clear all stage valids, out_valid, a3, a3_deriv and sample_cnt to 0, independent of clk.
REQ-023 SHALL discard in-flight samples on reset mid-operation; in_ready SHALL be 1 while reset is asserted and after it is released.
REQ-024 SHALL accept a sample on the first rising edge after reset deassertion.

Configuration
REQ-025 Macro A3_DERIV_EN: when defined, SHALL add stage 3 computing a3_deriv = (a3*(0x400-a3))>>10, truncated, registered with a3.
REQ-026 Without A3_DERIV_EN, SHALL omit port a3_deriv, the multiplier and stage 3.

Structure
REQ-027 Shared package ann_pkg SHALL hold the Q4.4/Q6.10 width and fraction constants, the ONE_Q610 constant (0x400) and the PLAN breakpoints and offsets.
REQ-028 SHALL instantiate one sub-module, plan_sigmoid_seg, combinational segment evaluation (|x|, segment -> y); all registers in a3_sigmoid.

Verification
REQ-029 z3=0x12 (1.125), out_ready=1 -> a3=0x310 after 2 cycles; with A3_DERIV_EN a3=0x310, a3_deriv=0x0B7 after 3 cycles.
REQ-030 Back-to-back z3=0x00, 0x0C, 0xEE, 0x28 -> a3=0x200, 0x2C0, 0x0F0, 0x3B0 on consecutive cycles; sample_cnt advances by 4.
REQ-031 Extremes z3=0x80, 0x7F, 0x50 (5.0) -> a3=0x000, 0x400, 0x400.
REQ-032 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 once out_valid rises, a3 held stable, no sample lost or duplicated after release.
REQ-033 Assert reset mid-stream with 2 samples in flight -> out_valid=0 and sample_cnt=0 at once; first post-reset sample appears with nominal latency.
REQ-034 Preload sample_cnt to all-ones (CNT_W=4, 15 transfers), then 1 more transfer -> sample_cnt=0.

Source files
------------

// File: rtl/ann_pkg.sv
// ============================================================================
// ann_pkg : fixed-point formats and PLAN sigmoid breakpoints shared by the ANN
// Rev 1.0
// ============================================================================
`default_nettype none

package ann_pkg;

  localparam int Q44_W     = 8;
  localparam int Q44_FRAC  = 4;
  localparam int Q610_W    = 16;
  localparam int Q610_FRAC = 10;
  localparam int ABS_W     = Q44_W + 1;

  localparam logic [Q610_W-1:0] ONE_Q610 = 16'h0400;

  // Breakpoints on |x| in Q4.4: 1.0, 2.375, 5.0
  localparam logic [ABS_W-1:0] PLAN_BP1 = 9'd16;
  localparam logic [ABS_W-1:0] PLAN_BP2 = 9'd38;
  localparam logic [ABS_W-1:0] PLAN_BP3 = 9'd80;

  // Segment offsets in Q6.10: 0.5, 0.625, 0.84375
  localparam logic [Q610_W-1:0] PLAN_OFF0 = 16'h0200;
  localparam logic [Q610_W-1:0] PLAN_OFF1 = 16'h0280;
  localparam logic [Q610_W-1:0] PLAN_OFF2 = 16'h0360;

  typedef enum logic [1:0] {
    SEG_0   = 2'd0,
    SEG_1   = 2'd1,
    SEG_2   = 2'd2,
    SEG_SAT = 2'd3
  } plan_seg_t;

  function automatic plan_seg_t plan_seg(input logic [ABS_W-1:0] mag);
    if (mag < PLAN_BP1)      return SEG_0;
    else if (mag < PLAN_BP2) return SEG_1;
    else if (mag < PLAN_BP3) return SEG_2;
    else                     return SEG_SAT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/plan_sigmoid_seg.sv
// ============================================================================
// plan_sigmoid_seg : combinational PLAN segment evaluation, (|x|, seg) -> y
// Rev 1.0
// ============================================================================
`default_nettype none

module plan_sigmoid_seg
  import ann_pkg::*;
(
  input  logic [ABS_W-1:0]  mag,
  input  plan_seg_t         seg,
  output logic [Q610_W-1:0] y
);

  logic [Q610_W-1:0] w_x;

  // Re-align Q4.4 magnitude onto the Q6.10 grid; every slope is then an exact right shift
  assign w_x = Q610_W'(mag) << (Q610_FRAC - Q44_FRAC);

  always_comb begin
    y = ONE_Q610;
    case (seg)
      SEG_0:   y = (w_x >> 2) + PLAN_OFF0;
      SEG_1:   y = (w_x >> 3) + PLAN_OFF1;
      SEG_2:   y = (w_x >> 5) + PLAN_OFF2;
      default: y = ONE_Q610;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/a3_sigmoid.sv
// ============================================================================
// a3_sigmoid : pipelined PLAN sigmoid with valid/ready and transfer counter.
// Optional macro A3_DERIV_EN adds a stage producing a3_deriv = a3*(1-a3).
// Rev 1.0
// ============================================================================
`default_nettype none

module a3_sigmoid
  import ann_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [Q44_W-1:0]  z3,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [Q610_W-1:0] a3,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef A3_DERIV_EN
  output logic [Q610_W-1:0] a3_deriv,
`endif
  output logic [CNT_W-1:0]  sample_cnt
);

  logic                w_stall;
  logic                w_accept;
  logic [ABS_W-1:0]    w_z_ext;
  logic [ABS_W-1:0]    w_mag;
  logic [Q610_W-1:0]   w_y;
  logic [Q610_W-1:0]   w_a3_next;

  logic                r_s1_valid;
  logic                r_s1_neg;
  logic [ABS_W-1:0]    r_s1_mag;
  plan_seg_t           r_s1_seg;
  logic                r_out_valid;
  logic [Q610_W-1:0]   r_a3;
  logic [CNT_W-1:0]    r_cnt;

  // Only a valid output the consumer refuses blocks the pipe; bubbles keep moving
  assign w_stall  = r_out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && in_ready;

  // 9-bit magnitude so that -8.0 (0x80) maps to +128 without overflow
  assign w_z_ext = {z3[Q44_W-1], z3};
  assign w_mag   = z3[Q44_W-1] ? (~w_z_ext + ABS_W'(1)) : w_z_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_neg   <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_seg   <= SEG_0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      r_s1_neg   <= z3[Q44_W-1];
      r_s1_mag   <= w_mag;
      r_s1_seg   <= plan_seg(w_mag);
    end
  end

  plan_sigmoid_seg u_seg (
    .mag (r_s1_mag),
    .seg (r_s1_seg),
    .y   (w_y)
  );

  assign w_a3_next = r_s1_neg ? (ONE_Q610 - w_y) : w_y;

`ifdef A3_DERIV_EN
  logic                r_s2_valid;
  logic [Q610_W-1:0]   r_s2_a3;
  logic [Q610_W-1:0]   r_deriv;
  logic [Q610_W-1:0]   w_one_minus;
  logic [2*Q610_W-1:0] w_prod;

  assign w_one_minus = ONE_Q610 - r_s2_a3;
  assign w_prod      = (2*Q610_W)'(r_s2_a3) * (2*Q610_W)'(w_one_minus);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_a3     <= '0;
      r_out_valid <= 1'b0;
      r_a3        <= '0;
      r_deriv     <= '0;
    end else if (!w_stall) begin
      r_s2_valid  <= r_s1_valid;
      r_s2_a3     <= w_a3_next;
      r_out_valid <= r_s2_valid;
      r_a3        <= r_s2_a3;
      r_deriv     <= Q610_W'(w_prod >> Q610_FRAC);
    end
  end

  assign a3_deriv = r_deriv;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_a3        <= '0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid;
      r_a3        <= w_a3_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_out_valid && out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign a3         = r_a3;
  assign sample_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_a3_sigmoid.sv
// ============================================================================
// tb_a3_sigmoid : directed-vector bench for a3_sigmoid (CNT_W=4 for wrap test)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_a3_sigmoid;

`ifdef A3_DERIV_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int NVEC = 17;

  typedef struct {
    logic [7:0]  z;
    logic [15:0] a3;
    logic [15:0] d;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  z3 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a3;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] a3_deriv;
  logic [3:0]  sample_cnt;

  int          checks = 0;
  int          failures = 0;
  vec_t        vec [NVEC];
  vec_t        exp_q [$];
  vec_t        mon_e;
  logic [3:0]  exp_cnt = '0;

  always #5 clk = ~clk;

  a3_sigmoid #(.CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .z3         (z3),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a3         (a3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef A3_DERIV_EN
    .a3_deriv   (a3_deriv),
`endif
    .sample_cnt (sample_cnt)
  );

`ifndef A3_DERIV_EN
  assign a3_deriv = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] z, input logic [15:0] a, input logic [15:0] d);
    vec[i].z  = z;
    vec[i].a3 = a;
    vec[i].d  = d;
  endtask

  // Present one sample, wait for acceptance, queue its expected output
  task automatic drive(input int idx);
    int n;
    n = 0;
    in_valid = 1'b1;
    z3 = vec[idx].z;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        check("drive_timeout", 32'd1, 32'd0);
        break;
      end
    end
    exp_q.push_back(vec[idx]);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Single sample into an empty pipe; measure edges from acceptance to out_valid
  task automatic lat_test(input int idx, input string name);
    int k;
    in_valid = 1'b1;
    z3 = vec[idx].z;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    exp_q.push_back(vec[idx]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    forever begin
      @(negedge clk);
      if (out_valid || k > 10) break;
      @(posedge clk);
      k++;
    end
    check({name, "_latency"}, k, LAT);
    drain();
  endtask

  // Scoreboard: every transfer is matched in order against queued expectations
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%0h required=none at %0t", a3, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("a3", a3, mon_e.a3);
`ifdef A3_DERIV_EN
        check("a3_deriv", a3_deriv, mon_e.d);
`endif
        check("sample_cnt", sample_cnt, exp_cnt);
        exp_cnt = exp_cnt + 4'd1;
      end
    end
  end

  initial begin
    set_vec(0,  8'h00, 16'h200, 16'h100);
    set_vec(1,  8'h0C, 16'h2C0, 16'h0DC);
    set_vec(2,  8'hEE, 16'h0F0, 16'h0B7);
    set_vec(3,  8'h28, 16'h3B0, 16'h049);
    set_vec(4,  8'h12, 16'h310, 16'h0B7);
    set_vec(5,  8'h80, 16'h000, 16'h000);
    set_vec(6,  8'h7F, 16'h400, 16'h000);
    set_vec(7,  8'h50, 16'h400, 16'h000);
    set_vec(8,  8'h10, 16'h300, 16'h0C0);
    set_vec(9,  8'h0F, 16'h2F0, 16'h0C7);
    set_vec(10, 8'h26, 16'h3AC, 16'h04D);
    set_vec(11, 8'h25, 16'h3A8, 16'h050);
    set_vec(12, 8'h4F, 16'h3FE, 16'h001);
    set_vec(13, 8'hF0, 16'h100, 16'h0C0);
    set_vec(14, 8'hB0, 16'h000, 16'h000);
    set_vec(15, 8'hFF, 16'h1F0, 16'h0FF);
    set_vec(16, 8'h01, 16'h210, 16'h0FF);

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_a3", a3, 16'h000);
    check("rst_cnt", sample_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // Back-to-back stream must come out as one unbroken run of four
    fork
      begin
        for (int i = 0; i < 4; i++) drive(i);
      end
      begin : watch
        int run;
        int w;
        run = 0;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 20);
        while (out_valid && run < 8) begin
          run++;
          @(negedge clk);
        end
        check("b2b_run", run, 4);
      end
    join
    drain();
    check("cnt_adv4", sample_cnt, 4);

    lat_test(4, "lat");

    for (int i = 5; i < NVEC; i++) drive(i);
    drain();
    check("cnt_after_table", sample_cnt, 1);

    // Consumer stall with input kept valid
    out_ready = 1'b0;
    fork
      begin
        for (int i = 8; i < 14; i++) drive(i);
      end
      begin : stall_ctl
        int w;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 20);
        check("stall_in_ready", in_ready, 0);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_hold_a3", a3, 16'h300);
          check("stall_hold_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("cnt_after_stall", sample_cnt, 7);

    // Asynchronous reset with two samples in flight
    drive(0);
    drive(1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_cnt", sample_cnt, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_a3", a3, 16'h000);
    exp_q.delete();
    exp_cnt = '0;
    @(posedge clk); #1;
    check("rst_hold_in_ready", in_ready, 1);
    reset = 1'b0;
    lat_test(7, "post_rst");

    // Counter wrap at CNT_W=4
    for (int i = 0; i < 14; i++) drive(i % NVEC);
    drain();
    check("cnt_full", sample_cnt, 4'hF);
    drive(6);
    drain();
    check("cnt_wrap", sample_cnt, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
